// File: rtl/riscv_state_pkg.sv
// Shared front-end state types: branch-predictor counter encoding and BPU FSM states.
package riscv_state_pkg;

  typedef logic [1:0] bp_counter_t;

  localparam bp_counter_t BP_SNT = 2'b00;
  localparam bp_counter_t BP_WNT = 2'b01;
  localparam bp_counter_t BP_WT  = 2'b10;
  localparam bp_counter_t BP_ST  = 2'b11;

  typedef enum logic {
    BP_INIT,
    BP_RUN
  } bp_state_t;

endpackage

// File: rtl/riscv_bpu_if.sv
// Fetch/branch-unit side of the branch prediction unit, bundled for the pipeline.
interface riscv_bpu_if
  import riscv_state_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BP_GLOBAL_BITS = 2
);
  logic                      id_stall_i;
  logic [XLEN-1:0]           if_pc_i;
  logic [BP_GLOBAL_BITS-1:0] bp_history_o;
  bp_counter_t               bp_bp_predict_o;
  logic                      bp_ready_o;
  logic                      bu_bp_update_i;
  logic [XLEN-1:0]           bu_pc_i;
  logic [BP_GLOBAL_BITS-1:0] bu_bp_history_i;
  bp_counter_t               bu_bp_predict_i;
  logic                      bu_bp_btaken_i;

  modport master (
    output id_stall_i, if_pc_i, bu_bp_update_i, bu_pc_i, bu_bp_history_i,
           bu_bp_predict_i, bu_bp_btaken_i,
    input  bp_history_o, bp_bp_predict_o, bp_ready_o
  );

  modport slave (
    input  id_stall_i, if_pc_i, bu_bp_update_i, bu_pc_i, bu_bp_history_i,
           bu_bp_predict_i, bu_bp_btaken_i,
    output bp_history_o, bp_bp_predict_o, bp_ready_o
  );
endinterface

// File: rtl/riscv_bp_ram.sv
// Pattern table storage: one write port, one registered read port, no reset on contents.
module riscv_bp_ram
  import riscv_state_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  bp_counter_t   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output bp_counter_t   rdata_o
);

  bp_counter_t mem [2**AW];

  // Read-before-write; the caller resolves same-index collisions.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o      <= mem[raddr_i];
  end

endmodule

// File: rtl/riscv_bpu.sv
// Gshare-style branch prediction unit: 2-bit counters indexed by {history, PC},
// initialised by a sweep after reset, trained by resolved branches from the BU.
module riscv_bpu
  import riscv_state_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int HAS_RVC        = 0,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int BP_LOCAL_BITS  = 10
) (
  input logic          rst_ni,
  input logic          clk_i,
  riscv_bpu_if.slave   bp
);

  localparam int G   = BP_GLOBAL_BITS;
  localparam int L   = BP_LOCAL_BITS;
  localparam int IDX = G + L;
  localparam int S   = (HAS_RVC != 0) ? 1 : 2;

  bp_state_t      state_q;
  logic [IDX-1:0] sweep_q;
  logic           ready_q;
  logic [G-1:0]   hist_q;
  logic [IDX-1:0] rd_idx, rd_idx_q, wr_idx;
  logic           we, re, upd_ok;
  bp_counter_t    wdata, trained, rdata;
  logic           byp_q;
  bp_counter_t    byp_val_q;
  logic [G:0]     hist_ext;

  assign upd_ok = (state_q == BP_RUN) && bp.bu_bp_update_i;

  always_comb begin
    trained = bp.bu_bp_predict_i;
    if (bp.bu_bp_btaken_i) begin
      if (bp.bu_bp_predict_i != BP_ST)  trained = bp.bu_bp_predict_i + 2'd1;
    end else begin
      if (bp.bu_bp_predict_i != BP_SNT) trained = bp.bu_bp_predict_i - 2'd1;
    end
  end

  // A stalled decode keeps re-reading the held index so later writes to it still show up.
  assign rd_idx = bp.id_stall_i ? rd_idx_q : {hist_q, bp.if_pc_i[S+L-1:S]};

  assign we     = (state_q == BP_INIT) || upd_ok;
  assign wr_idx = (state_q == BP_INIT) ? sweep_q
                                       : {bp.bu_bp_history_i, bp.bu_pc_i[S+L-1:S]};
  assign wdata  = (state_q == BP_INIT) ? BP_WNT : trained;
  // Reading starts on the final sweep write so the first RUN cycle has a valid prediction.
  assign re     = ready_q || (&sweep_q);

  riscv_bp_ram #(.AW(IDX)) u_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (wr_idx),
    .wdata_i (wdata),
    .re_i    (re),
    .raddr_i (rd_idx),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BP_INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        BP_INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (&sweep_q) begin
            state_q <= BP_RUN;
            ready_q <= 1'b1;
          end
        end
        BP_RUN:  state_q <= BP_RUN;
        default: state_q <= BP_INIT;
      endcase
    end
  end

  assign hist_ext = {hist_q, bp.bu_bp_btaken_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q    <= '0;
      rd_idx_q  <= '0;
      byp_q     <= 1'b0;
      byp_val_q <= BP_SNT;
    end else begin
      if (upd_ok) hist_q <= hist_ext[G-1:0];
      rd_idx_q  <= rd_idx;
      byp_q     <= we && (wr_idx == rd_idx);
      byp_val_q <= wdata;
    end
  end

  assign bp.bp_history_o    = hist_q;
  assign bp.bp_ready_o      = ready_q;
  assign bp.bp_bp_predict_o = !ready_q ? BP_SNT : (byp_q ? byp_val_q : rdata);

endmodule

// File: tb/tb_riscv_bpu.sv
// Directed bench for riscv_bpu (G=2, L=4, 4-byte PCs) with a table-level reference model.
module tb_riscv_bpu;
  import riscv_state_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  riscv_bpu_if #(.XLEN(32), .BP_GLOBAL_BITS(2)) bif ();

  riscv_bpu #(.XLEN(32), .HAS_RVC(0), .BP_GLOBAL_BITS(2), .BP_LOCAL_BITS(4)) dut (
    .rst_ni (rst_n),
    .clk_i  (clk),
    .bp     (bif)
  );

  // Reference model: a 64-entry array of counters, a history integer and an init countdown.
  int m_tbl [64];
  int m_hist, m_pred, m_left, m_idx;
  int m_ready;

  function automatic int rd_sel();
    return bif.id_stall_i ? m_idx : (m_hist * 16 + int'((bif.if_pc_i >> 2) & 32'hF));
  endfunction

  function automatic int wr_sel();
    return int'(bif.bu_bp_history_i) * 16 + int'((bif.bu_pc_i >> 2) & 32'hF);
  endfunction

  function automatic int train();
    int p = int'(bif.bu_bp_predict_i);
    if (bif.bu_bp_btaken_i) return (p == 3) ? 3 : p + 1;
    return (p == 0) ? 0 : p - 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 0; m_hist <= 0; m_pred <= 0; m_left <= 64; m_idx <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_idx  <= rd_sel();
      if (m_left == 1) begin
        m_ready <= 1;
        m_pred  <= 1;
        for (int i = 0; i < 64; i++) m_tbl[i] <= 1;
      end
    end else begin
      if (bif.bu_bp_update_i) begin
        m_tbl[wr_sel()] <= train();
        m_hist <= ((m_hist * 2) + int'(bif.bu_bp_btaken_i)) % 4;
      end
      m_pred <= (bif.bu_bp_update_i && wr_sel() == rd_sel()) ? train() : m_tbl[rd_sel()];
      m_idx  <= rd_sel();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_ready",   32'(bif.bp_ready_o),      32'(m_ready));
    chk("cyc_history", 32'(bif.bp_history_o),    32'(m_hist));
    chk("cyc_predict", 32'(bif.bp_bp_predict_o), 32'(m_pred));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] h, input logic [1:0] p, input logic t);
    bif.bu_bp_update_i  = 1'b1;
    bif.bu_pc_i         = pc;
    bif.bu_bp_history_i = h;
    bif.bu_bp_predict_i = p;
    bif.bu_bp_btaken_i  = t;
    step();
    bif.bu_bp_update_i  = 1'b0;
  endtask

  task automatic pulse_reset(input string nm);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk({nm, "_ready"}, 32'(bif.bp_ready_o), 0);
    chk({nm, "_hist"},  32'(bif.bp_history_o), 0);
    chk({nm, "_pred"},  32'(bif.bp_bp_predict_o), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic wait_init(input string nm);
    repeat (63) step();
    chk({nm, "_ready_lo"}, 32'(bif.bp_ready_o), 0);
    step();
    chk({nm, "_ready_hi"}, 32'(bif.bp_ready_o), 1);
  endtask

  initial begin
    bif.id_stall_i = 1'b0; bif.if_pc_i = '0; bif.bu_bp_update_i = 1'b0;
    bif.bu_pc_i = '0; bif.bu_bp_history_i = '0; bif.bu_bp_predict_i = '0; bif.bu_bp_btaken_i = 1'b0;

    #3;
    chk("rst_ready", 32'(bif.bp_ready_o), 0);
    chk("rst_hist",  32'(bif.bp_history_o), 0);
    chk("rst_pred",  32'(bif.bp_bp_predict_o), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    wait_init("init");

    // Every PC predicts weak-NT straight after the sweep.
    for (int k = 0; k < 64; k++) begin
      bif.if_pc_i = 32'(k * 4);
      step();
      chk("idle_pred", 32'(bif.bp_bp_predict_o), 1);
    end

    // Train PC 0x40 taken three times with the fed-back counter.
    bif.if_pc_i = 32'h0;
    upd(32'h40, 2'b00, 2'b01, 1'b1); chk("train1_hist", 32'(bif.bp_history_o), 1);
    upd(32'h40, 2'b00, 2'b10, 1'b1); chk("train2_hist", 32'(bif.bp_history_o), 3);
    upd(32'h40, 2'b00, 2'b11, 1'b1); chk("train3_hist", 32'(bif.bp_history_o), 3);
    chk("train_model_entry", 32'(m_tbl[0]), 3);
    upd(32'h44, 2'b00, 2'b01, 1'b0); chk("nt1_hist", 32'(bif.bp_history_o), 2);
    upd(32'h44, 2'b00, 2'b01, 1'b0); chk("nt2_hist", 32'(bif.bp_history_o), 0);
    bif.if_pc_i = 32'h40;
    step();
    chk("train_read", 32'(bif.bp_bp_predict_o), 3);

    // Strong-NT stays strong-NT.
    upd(32'h48, 2'b00, 2'b00, 1'b0); chk("snt_hist", 32'(bif.bp_history_o), 0);
    bif.if_pc_i = 32'h48;
    step();
    chk("snt_read", 32'(bif.bp_bp_predict_o), 0);

    // Same-cycle read and write at index {01, 4}.
    upd(32'h3C, 2'b11, 2'b01, 1'b1); chk("pre_coll_hist", 32'(bif.bp_history_o), 1);
    bif.if_pc_i = 32'h10;
    upd(32'h10, 2'b01, 2'b01, 1'b1);
    chk("coll_pred", 32'(bif.bp_bp_predict_o), 2);
    chk("coll_hist", 32'(bif.bp_history_o), 3);

    // Stall: prediction holds while PC changes; an unrelated update still shifts history.
    bif.if_pc_i = 32'h40;
    step();
    chk("prestall_pred", 32'(bif.bp_bp_predict_o), 1);
    bif.id_stall_i = 1'b1;
    bif.if_pc_i = 32'h80;
    upd(32'h3C, 2'b00, 2'b01, 1'b0);
    chk("stall1_pred", 32'(bif.bp_bp_predict_o), 1);
    chk("stall1_hist", 32'(bif.bp_history_o), 2);
    bif.if_pc_i = 32'h44; step(); chk("stall2_pred", 32'(bif.bp_bp_predict_o), 1);
    bif.if_pc_i = 32'h48; step(); chk("stall3_pred", 32'(bif.bp_bp_predict_o), 1);
    // Update hitting the held index {11, 0} refreshes the held prediction.
    upd(32'h40, 2'b11, 2'b01, 1'b1);
    chk("stall_refresh_pred", 32'(bif.bp_bp_predict_o), 2);
    chk("stall_refresh_hist", 32'(bif.bp_history_o), 1);
    bif.id_stall_i = 1'b0;
    step();

    // Reset mid-RUN, then again at INIT cycle 20 with an ignored update strobe.
    pulse_reset("run_rst");
    repeat (20) step();
    upd(32'h40, 2'b00, 2'b01, 1'b1);
    chk("init_upd_hist", 32'(bif.bp_history_o), 0);
    pulse_reset("init_rst");
    wait_init("reinit");
    bif.if_pc_i = 32'h40;
    step();
    chk("reinit_read", 32'(bif.bp_bp_predict_o), 1);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
